register_write_sequencer: RTL and testbench

REGISTER_WRITE_SEQUENCER -- requirements
Module: register_write_sequencer

---
 rtl/fpga9685_pkg.sv | 9 +
 rtl/register_pointer_next.sv | 14 +
 rtl/register_write_sequencer.sv | 99 +++++++++
 tb/tb_register_write_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fpga9685_pkg.sv
// fpga9685_pkg: shared register map addresses and sequencer state encoding
package fpga9685_pkg;
  localparam logic [7:0] MODE1 = 8'h00;
  localparam logic [7:0] LED15_OFF_H = 8'h45;
  localparam logic [7:0] ALL_LED_ON_L = 8'hFA;
  localparam logic [7:0] PRE_SCALE = 8'hFE;
  localparam logic [7:0] TESTMODE = 8'hFF;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;
endpackage

// File: rtl/register_pointer_next.sv
// register_pointer_next: pointer increment/wrap and register writability rules
module register_pointer_next
  import fpga9685_pkg::*;
(
  input  logic [7:0] pointer_i,
  input  logic       sleep_i,
  output logic [7:0] next_pointer_o,
  output logic       writable_o
);
  logic w_reserved;
  assign w_reserved = pointer_i > LED15_OFF_H && pointer_i < ALL_LED_ON_L;
  assign next_pointer_o = (pointer_i == LED15_OFF_H || pointer_i == TESTMODE) ? 8'h00 : pointer_i + 8'h01;
  assign writable_o = !w_reserved && !(pointer_i == PRE_SCALE && !sleep_i);
endmodule

// File: rtl/register_write_sequencer.sv
// register_write_sequencer: turns I2C write bytes into register file write strobes
module register_write_sequencer
  import fpga9685_pkg::*;
#(
  parameter int WRITE_HOLD = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  input  logic       auto_increment_i,
  input  logic       sleep_i,
  output logic [7:0] write_register_id_o,
  output logic [7:0] write_register_value_o,
  output logic       write_enable_o,
  output logic [7:0] pointer_o,
  output logic       busy_o,
  output logic       dropped_o
);
  localparam logic [2:0] LAST = 3'(WRITE_HOLD - 1);
  state_t r_state;
  logic [7:0] r_pointer;
  logic [7:0] r_id;
  logic [7:0] r_value;
  logic [2:0] r_cnt;
  logic r_ai;
  logic r_pend;
  logic r_pend_stop;
  logic r_dropped;
  logic [7:0] w_next;
  logic w_writable;
  register_pointer_next u_next (
    .pointer_i(r_pointer),
    .sleep_i(sleep_i),
    .next_pointer_o(w_next),
    .writable_o(w_writable)
  );
  assign byte_ready_o = r_state == ADDR || r_state == DATA;
  assign busy_o = r_state != IDLE;
  assign write_enable_o = r_state == WRITE;
  assign write_register_id_o = r_id;
  assign write_register_value_o = r_value;
  assign pointer_o = r_pointer;
  assign dropped_o = r_dropped;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_pointer <= 8'h00;
      r_id <= 8'h00;
      r_value <= 8'h00;
      r_cnt <= 3'd0;
      r_ai <= 1'b0;
      r_pend <= 1'b0;
      r_pend_stop <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case (r_state)
        IDLE: if (start_i) r_state <= ADDR;
        ADDR, DATA: begin
          if (stop_i) r_state <= IDLE;
          else if (start_i) r_state <= ADDR;
          else if (byte_valid_i) begin
            if (r_state == ADDR) begin
              r_pointer <= byte_i;
              r_state <= DATA;
            end else if (w_writable) begin
              r_id <= r_pointer;
              r_value <= byte_i;
              r_ai <= auto_increment_i;
              r_cnt <= 3'd0;
              r_state <= WRITE;
            end else begin
              r_dropped <= 1'b1;
              if (auto_increment_i) r_pointer <= w_next;
            end
          end
        end
        WRITE: begin
          r_cnt <= r_cnt + 3'd1;
          if (start_i || stop_i) begin
            r_pend <= 1'b1;
            r_pend_stop <= stop_i;
          end
          if (r_cnt == LAST) begin
            if (r_ai) r_pointer <= w_next;
            r_pend <= 1'b0;
            r_pend_stop <= 1'b0;
            r_state <= (start_i || stop_i) ? (stop_i ? IDLE : ADDR) : r_pend ? (r_pend_stop ? IDLE : ADDR) : DATA;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_write_sequencer.sv
// tb_register_write_sequencer: directed self-checking bench for the write sequencer
module tb_register_write_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_d = 8'h00;
  logic ai = 1'b0;
  logic sleep = 1'b0;
  logic ready, we, busy, dropped;
  logic [7:0] id, value, pointer;
  logic ready4, we4, busy4, dropped4;
  logic [7:0] id4, value4, pointer4;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  register_write_sequencer #(.WRITE_HOLD(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .byte_valid_i(byte_valid), .byte_i(byte_d), .byte_ready_o(ready),
    .auto_increment_i(ai), .sleep_i(sleep),
    .write_register_id_o(id), .write_register_value_o(value), .write_enable_o(we),
    .pointer_o(pointer), .busy_o(busy), .dropped_o(dropped)
  );
  register_write_sequencer #(.WRITE_HOLD(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .byte_valid_i(byte_valid), .byte_i(byte_d), .byte_ready_o(ready4),
    .auto_increment_i(ai), .sleep_i(sleep),
    .write_register_id_o(id4), .write_register_value_o(value4), .write_enable_o(we4),
    .pointer_o(pointer4), .busy_o(busy4), .dropped_o(dropped4)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_d = b;
    tick();
    byte_valid = 1'b0;
  endtask
  task automatic send_write(input string tag, input logic [7:0] b, input logic [7:0] exp_id, input logic [7:0] exp_ptr);
    send(b);
    chk({tag, "_we"}, {7'd0, we}, 8'h01);
    chk({tag, "_id"}, id, exp_id);
    chk({tag, "_val"}, value, b);
    chk({tag, "_rdy"}, {7'd0, ready}, 8'h00);
    tick();
    chk({tag, "_we_off"}, {7'd0, we}, 8'h00);
    chk({tag, "_ptr"}, pointer, exp_ptr);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ptr", pointer, 8'h00);
    chk("rst_we", {7'd0, we}, 8'h00);
    chk("rst_id", id, 8'h00);
    chk("rst_val", value, 8'h00);
    chk("rst_rdy", {7'd0, ready}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_drop", {7'd0, dropped}, 8'h00);
    rst = 1'b0;
    tick();
    byte_valid = 1'b1;
    byte_d = 8'h33;
    tick();
    byte_valid = 1'b0;
    chk("idle_ignore_busy", {7'd0, busy}, 8'h00);
    chk("idle_ignore_ptr", pointer, 8'h00);
    ai = 1'b1;
    do_start();
    chk("start_busy", {7'd0, busy}, 8'h01);
    chk("start_rdy", {7'd0, ready}, 8'h01);
    send(8'h42);
    chk("addr_ptr", pointer, 8'h42);
    chk("addr_no_we", {7'd0, we}, 8'h00);
    send_write("ai0", 8'hDE, 8'h42, 8'h43);
    send_write("ai1", 8'h4D, 8'h43, 8'h44);
    send_write("ai2", 8'hBE, 8'h44, 8'h45);
    send_write("ai3", 8'hEF, 8'h45, 8'h00);
    do_stop();
    chk("stop_busy", {7'd0, busy}, 8'h00);
    chk("stop_ptr", pointer, 8'h00);
    ai = 1'b0;
    do_start();
    send(8'h06);
    send_write("noai0", 8'h11, 8'h06, 8'h06);
    send_write("noai1", 8'h22, 8'h06, 8'h06);
    do_stop();
    sleep = 1'b0;
    do_start();
    send(8'hFE);
    send(8'h1E);
    chk("pre_drop", {7'd0, dropped}, 8'h01);
    chk("pre_no_we", {7'd0, we}, 8'h00);
    tick();
    chk("pre_drop_pulse", {7'd0, dropped}, 8'h00);
    chk("pre_no_we2", {7'd0, we}, 8'h00);
    chk("pre_ptr", pointer, 8'hFE);
    do_stop();
    sleep = 1'b1;
    do_start();
    send(8'hFE);
    send_write("pre_sleep", 8'h1E, 8'hFE, 8'hFE);
    do_stop();
    ai = 1'b1;
    do_start();
    send(8'hFD);
    send_write("wrap0", 8'hAA, 8'hFD, 8'hFE);
    send_write("wrap1", 8'hBB, 8'hFE, 8'hFF);
    send_write("wrap2", 8'hCC, 8'hFF, 8'h00);
    do_stop();
    sleep = 1'b0;
    do_start();
    send(8'h50);
    send(8'h77);
    chk("rsv_drop", {7'd0, dropped}, 8'h01);
    chk("rsv_no_we", {7'd0, we}, 8'h00);
    chk("rsv_ptr", pointer, 8'h51);
    stop = 1'b1;
    byte_valid = 1'b1;
    byte_d = 8'h66;
    tick();
    stop = 1'b0;
    byte_valid = 1'b0;
    chk("stopwin_busy", {7'd0, busy}, 8'h00);
    chk("stopwin_ptr", pointer, 8'h51);
    chk("stopwin_we", {7'd0, we}, 8'h00);
    do_reset();
    do_start();
    send(8'h10);
    send(8'h99);
    chk("h4_we1", {7'd0, we4}, 8'h01);
    chk("h4_id", id4, 8'h10);
    chk("h4_val", value4, 8'h99);
    tick();
    chk("h4_we2", {7'd0, we4}, 8'h01);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("h4_we3", {7'd0, we4}, 8'h01);
    tick();
    chk("h4_we4", {7'd0, we4}, 8'h01);
    chk("h4_busy_during", {7'd0, busy4}, 8'h01);
    tick();
    chk("h4_we_off", {7'd0, we4}, 8'h00);
    chk("h4_busy", {7'd0, busy4}, 8'h00);
    chk("h4_ptr", pointer4, 8'h11);
    do_reset();
    do_start();
    send(8'h20);
    send(8'h55);
    chk("mid_we", {7'd0, we}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", {7'd0, we}, 8'h00);
    chk("mid_rst_ptr", pointer, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
